// File: rtl/ifetch.sv
// Instruction fetch unit: fetch PC, a small prefetch queue and redirect/flush handling.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky misaligned-redirect flag that freezes fetch.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    input  logic [31:0] idata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int          PW        = (QDEPTH == 4) ? 2 : 1;
    localparam logic [PW:0] CNT_ZERO  = (PW + 1)'(0);
    localparam logic [PW:0] CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0] CNT_FULL  = (PW + 1)'(QDEPTH);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0]   fpc_q, fpc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [31:0]   mem_pc_q   [QDEPTH];
    logic [31:0]   mem_data_q [QDEPTH];
    logic          push_s, pop_s, full_s, freeze_s;
    logic          err_q, err_d;

    // Next-state logic for fetch PC, queue pointers and the sticky error flag.
    always_comb begin
        full_s = (cnt_q == CNT_FULL);
        pop_s  = (cnt_q != CNT_ZERO) && instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
        freeze_s = err_q;
        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
`else
        freeze_s = 1'b0;
        err_d    = 1'b0;
`endif
        push_s = !redirect && !freeze_s && (!full_s || pop_s);
        fpc_d  = fpc_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (redirect) begin
            // Flush wins over any pop/push; low address bits are dropped.
            fpc_d  = redirect_pc & 32'hFFFF_FFFC;
            head_d = PTR_ZERO;
            tail_d = PTR_ZERO;
            cnt_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                fpc_d  = fpc_q + 32'd4;
                tail_d = tail_q + PTR_ONE;
            end else begin
                fpc_d  = fpc_q;
            end
            if (pop_s) begin
                head_d = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers and queue storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q  <= RESET_PC;
            head_q <= PTR_ZERO;
            tail_q <= PTR_ZERO;
            cnt_q  <= CNT_ZERO;
            err_q  <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem_pc_q[i]   <= 32'h0000_0000;
                mem_data_q[i] <= 32'h0000_0000;
            end
        end else begin
            fpc_q  <= fpc_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            if (push_s) begin
                mem_pc_q[tail_q]   <= fpc_q;
                mem_data_q[tail_q] <= idata;
            end
        end
    end

    assign iaddr       = fpc_q;
    assign instr_valid = (cnt_q != CNT_ZERO);
    assign instr       = mem_data_q[head_q];
    assign instr_pc    = mem_pc_q[head_q];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_err = err_q;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch; a second instance exercises RESET_PC wrap and QDEPTH=4.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic [31:0] iaddr, idata, instr, instr_pc;
    logic        instr_valid;
    logic [31:0] w_iaddr, w_idata, w_instr, w_instr_pc;
    logic        w_instr_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_err, w_misalign_err;
`endif
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    // imem model: word at address a is a
    assign idata   = iaddr;
    assign w_idata = w_iaddr;

    ifetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut (
        .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) u_wrap (
        .clk(clk), .reset(reset), .iaddr(w_iaddr), .idata(w_idata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready),
        .instr(w_instr), .instr_pc(w_instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .misalign_err(w_misalign_err)
`endif
    );

    task automatic apply_reset(input logic rdy);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0000_0000;
        instr_ready = rdy;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; instr_ready = 1'b0;
        #1;
        total_cnt++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) $display("FAIL reset_outputs valid=%b instr=%h pc=%h want 0/0/0", instr_valid, instr, instr_pc);
        else pass_cnt++;
        total_cnt++;
        if (iaddr !== 32'h0) $display("FAIL reset_iaddr got=%h want=00000000", iaddr);
        else pass_cnt++;
        total_cnt++;
        if (w_iaddr !== 32'hFFFF_FFF8 || w_instr_valid !== 1'b0) $display("FAIL reset_wrap_iaddr got=%h valid=%b want=fffffff8/0", w_iaddr, w_instr_valid);
        else pass_cnt++;
`ifdef FETCH_MISALIGN_TRAP_EN
        total_cnt++;
        if (misalign_err !== 1'b0) $display("FAIL reset_misalign got=%b want=0", misalign_err);
        else pass_cnt++;
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_stream();
        apply_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total_cnt++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4) || instr !== 32'(k * 4))
                $display("FAIL stream_%0d valid=%b pc=%h instr=%h want 1/%h/%h", k, instr_valid, instr_pc, instr, 32'(k * 4), 32'(k * 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total_cnt++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL bp_hold_%0d valid=%b pc=%h want 1/00000000", k, instr_valid, instr_pc);
            else pass_cnt++;
        end
        total_cnt++;
        if (iaddr !== 32'h8) $display("FAIL bp_iaddr got=%h want=00000008", iaddr);
        else pass_cnt++;
        total_cnt++;
        if (w_iaddr !== 32'h8 || w_instr_pc !== 32'hFFFF_FFF8) $display("FAIL bp_depth4 iaddr=%h pc=%h want 00000008/fffffff8", w_iaddr, w_instr_pc);
        else pass_cnt++;
        instr_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            total_cnt++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'(k * 4)) $display("FAIL bp_drain_%0d valid=%b pc=%h want 1/%h", k, instr_valid, instr_pc, 32'(k * 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_redirect();
        apply_reset(1'b0);
        repeat (3) @(negedge clk);
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        redirect = 1'b0;
        total_cnt++;
        if (instr_valid !== 1'b0 || iaddr !== 32'h100) $display("FAIL redir_flush valid=%b iaddr=%h want 0/00000100", instr_valid, iaddr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h100) $display("FAIL redir_target valid=%b pc=%h instr=%h want 1/00000100/00000100", instr_valid, instr_pc, instr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h104) $display("FAIL redir_next valid=%b pc=%h want 1/00000104", instr_valid, instr_pc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect_pc = 32'h0000_0300;
        total_cnt++;
        if (instr_valid !== 1'b0 || iaddr !== 32'h200) $display("FAIL b2b_first valid=%b iaddr=%h want 0/00000200", instr_valid, iaddr);
        else pass_cnt++;
        @(negedge clk);
        redirect = 1'b0;
        total_cnt++;
        if (instr_valid !== 1'b0 || iaddr !== 32'h300) $display("FAIL b2b_second valid=%b iaddr=%h want 0/00000300", instr_valid, iaddr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h300) $display("FAIL b2b_target valid=%b pc=%h want 1/00000300", instr_valid, instr_pc);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_pc !== 32'h304) $display("FAIL b2b_next pc=%h want 00000304", instr_pc);
        else pass_cnt++;
    endtask

    task automatic test_misalign();
        apply_reset(1'b1);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        total_cnt++;
        if (instr_valid !== 1'b0) $display("FAIL mis_flush valid=%b want 0", instr_valid);
        else pass_cnt++;
`ifdef FETCH_MISALIGN_TRAP_EN
        total_cnt++;
        if (misalign_err !== 1'b1) $display("FAIL mis_err got=%b want=1", misalign_err);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (instr_valid !== 1'b0 || misalign_err !== 1'b1) $display("FAIL mis_frozen valid=%b err=%b want 0/1", instr_valid, misalign_err);
        else pass_cnt++;
`else
        total_cnt++;
        if (iaddr !== 32'h100) $display("FAIL mis_align_iaddr got=%h want=00000100", iaddr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100) $display("FAIL mis_target valid=%b pc=%h want 1/00000100", instr_valid, instr_pc);
        else pass_cnt++;
`endif
    endtask

    task automatic test_wrap();
        apply_reset(1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total_cnt++;
            if (w_instr_valid !== 1'b1 || w_instr_pc !== 32'hFFFF_FFF8 + 32'(k * 4) || w_instr !== w_instr_pc)
                $display("FAIL wrap_%0d valid=%b pc=%h instr=%h want 1/%h", k, w_instr_valid, w_instr_pc, w_instr, 32'hFFFF_FFF8 + 32'(k * 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        apply_reset(1'b0);
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (instr_valid !== 1'b1 || iaddr !== 32'h8) $display("FAIL areset_pre valid=%b iaddr=%h want 1/00000008", instr_valid, iaddr);
        else pass_cnt++;
        #1 reset = 1'b1;
        #1;
        total_cnt++;
        if (instr_valid !== 1'b0 || iaddr !== 32'h0 || instr_pc !== 32'h0 || instr !== 32'h0)
            $display("FAIL areset_now valid=%b iaddr=%h pc=%h instr=%h want 0/0/0/0", instr_valid, iaddr, instr_pc, instr);
        else pass_cnt++;
        #1 reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) $display("FAIL areset_first valid=%b pc=%h want 1/00000000", instr_valid, instr_pc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_misalign();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 The block SHALL provide parameter QDEPTH, default 2, meaning fetch-queue entries; legal values 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 iaddr  output  32  instruction address to imem; combinational copy of the fetch PC register.
REQ-006 idata  input  32  instruction word returned combinationally by imem for iaddr.
REQ-007 redirect  input  1  branch/jump taken; flush and restart fetch.
REQ-008 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-009 instr_valid  output  1  queue head holds a valid instruction.
REQ-010 instr_ready  input  1  decode accepts the head this cycle.
REQ-011 instr  output  32  instruction word at the queue head.
REQ-012 instr_pc  output  32  address of instr.
REQ-013 misalign_err  output  1  sticky misaligned-redirect flag; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-014 The block SHALL hold fetch PC register fpc; iaddr SHALL equal fpc at all times.
REQ-015 Push: when redirect=0 and the queue is not full, or full with a pop in the same cycle, the block SHALL write {fpc, idata} at the tail and set fpc <= fpc + 4.
REQ-016 Otherwise fpc SHALL hold and no entry SHALL be written; no instruction is dropped or duplicated.
REQ-017 Pop: when instr_valid=1 and instr_ready=1, the head SHALL be removed at the clock edge.
REQ-018 instr_valid SHALL be 1 exactly when the queue is non-empty; instr and instr_pc SHALL be registered queue outputs, stable while instr_valid=1 and instr_ready=0.
REQ-019 Push and pop in the same cycle SHALL leave occupancy unchanged, including at full and at 1 entry.
REQ-020 Redirect has highest priority: the queue SHALL be emptied, fpc <= {redirect_pc[31:2], 2'b00}, no push that cycle; a simultaneous pop is accepted by decode but its entry is discarded with the flush.
REQ-021 After redirect, instr_valid SHALL be 0 in the next cycle and the target instruction SHALL appear with instr_valid=1 one cycle later (redirect-to-valid latency 2 edges).
REQ-022 Back-to-back redirects SHALL each restart from the latest redirect_pc.
REQ-023 fpc arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 SHALL wrap to 32'h0000_0000.
REQ-024 Steady state with instr_ready=1 held: one instruction per cycle, sequential PCs, no bubbles.

Reset
REQ-025 While reset=1 the block SHALL force fpc=RESET_PC, queue empty, instr_valid=0, instr=0, instr_pc=0, misalign_err=0, asynchronously.
REQ-026 Reset asserted mid-stream SHALL discard all queued entries; first instruction (at RESET_PC) SHALL show instr_valid=1 after the first rising edge following reset deassertion.

Configuration
REQ-027 With macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 SHALL set misalign_err=1 (sticky until reset), flush the queue, and freeze fetch (no pushes) until reset.
REQ-028 Without FETCH_MISALIGN_TRAP_EN: port misalign_err SHALL not exist and redirect_pc[1:0] SHALL be silently cleared per REQ-020.

Verification
REQ-029 Reset release, instr_ready=1, imem word(a)=a: instr_pc sequence 0x0,0x4,0x8,0xC on consecutive cycles, instr equals address.
REQ-030 instr_ready=0 for 5 cycles from reset (QDEPTH=2): queue holds 0x0,0x4; iaddr stays 0x8; on ready=1 outputs 0x0,0x4,0x8 without gap or duplicate.
REQ-031 redirect=1, redirect_pc=0x100 while queue full and ready=1: next cycle instr_valid=0, following cycle instr_pc=0x100, then 0x104.
REQ-032 RESET_PC=32'hFFFF_FFF8, ready=1: instr_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-033 redirect_pc=0x103: without macro next fetched instr_pc=0x100; with FETCH_MISALIGN_TRAP_EN misalign_err=1, instr_valid stays 0.
REQ-034 reset pulsed asynchronously between edges with 2 entries queued: instr_valid drops immediately, iaddr=RESET_PC before the next edge.
